// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings and default latencies.
// MDU_MADD_EN adds the MADD/MADDU accumulate ops to the long-op decode.
package mdu_pkg;

   localparam int OP_W             = 4;
   localparam int MULT_CYCLES_DEF  = 5;
   localparam int DIV_CYCLES_DEF   = 10;

   typedef enum logic [OP_W-1:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MTHI  = 4'd5,
      MDU_MTLO  = 4'd6,
      MDU_MADD  = 4'd7,
      MDU_MADDU = 4'd8
   } mdu_op_e;

   // Ops that occupy the unit for MULT_CYCLES.
   function automatic logic is_mul_op(input logic [OP_W-1:0] op);
`ifdef MDU_MADD_EN
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD) || (op == MDU_MADDU);
`else
      return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
   endfunction

   function automatic logic is_div_op(input logic [OP_W-1:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_if.sv
// Pipeline <-> MDU connection: issue (op + forwarded operands) and HI/LO/stall status back.
interface mdu_if;
   import mdu_pkg::*;

   logic            start;
   logic [OP_W-1:0] op;
   logic [31:0]     rs_val;
   logic [31:0]     rt_val;
   logic            busy;
   logic            stall_req;
   logic [31:0]     hi;
   logic [31:0]     lo;

   modport master (output start, op, rs_val, rt_val, input busy, stall_req, hi, lo);
   modport slave  (input start, op, rs_val, rt_val, output busy, stall_req, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit {hi,lo} result for the long MDU ops; other ops return the current {hi,lo}.
// MDU_MADD_EN enables the accumulate path (the 64-bit adder exists only then).
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [OP_W-1:0] op,
   input  logic [31:0]     rs_val,
   input  logic [31:0]     rt_val,
   input  logic [31:0]     hi,
   input  logic [31:0]     lo,
   output logic [63:0]     res
);

   logic [63:0] prod_u, prod_s;
   logic [31:0] mag_a, mag_b, quo_m, rem_m, quo_s, rem_s;

   assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};
   // Low 64 bits of the sign-extended product equal the signed product.
   assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};

   // Signed divide on magnitudes: 0x80000000 has magnitude 0x80000000 unsigned,
   // so INT_MIN / -1 wraps to 0x80000000 naturally.
   assign mag_a = rs_val[31] ? (32'd0 - rs_val) : rs_val;
   assign mag_b = rt_val[31] ? (32'd0 - rt_val) : rt_val;
   assign quo_m = mag_a / mag_b;
   assign rem_m = mag_a % mag_b;
   assign quo_s = (rs_val[31] ^ rt_val[31]) ? (32'd0 - quo_m) : quo_m;
   assign rem_s = rs_val[31] ? (32'd0 - rem_m) : rem_m;

   always_comb begin
      res = {hi, lo};
      unique case (op)
         MDU_MULT:  res = prod_s;
         MDU_MULTU: res = prod_u;
         MDU_DIV:   if (rt_val != 32'd0) res = {rem_s, quo_s};
         MDU_DIVU:  if (rt_val != 32'd0) res = {rs_val % rt_val, rs_val / rt_val};
`ifdef MDU_MADD_EN
         MDU_MADD:  res = {hi, lo} + prod_s;
         MDU_MADDU: res = {hi, lo} + prod_u;
`endif
         default:   res = {hi, lo};
      endcase
   end

endmodule

// File: rtl/mdu.sv
// MIPS EX-stage multiply/divide unit: HI/LO registers, pending result and busy counter.
// Define MDU_MADD_EN to accept MADD/MADDU (ops 7/8); otherwise they behave as NONE.
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
   input  logic  clk,
   input  logic  reset,
   mdu_if.slave  bus
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e        state;
   logic [CW-1:0] cnt;
   logic          busy_q;
   logic [31:0]   hi_q, lo_q;
   logic [63:0]   pend;
   logic [63:0]   res;

   mdu_arith u_arith (
      .op     (bus.op),
      .rs_val (bus.rs_val),
      .rt_val (bus.rt_val),
      .hi     (hi_q),
      .lo     (lo_q),
      .res    (res)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         pend   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  if (is_mul_op(bus.op)) begin
                     pend   <= res;
                     cnt    <= CW'(MULT_CYCLES);
                     busy_q <= 1'b1;
                     state  <= S_RUN;
                  end else if (is_div_op(bus.op)) begin
                     pend   <= res;
                     cnt    <= CW'(DIV_CYCLES);
                     busy_q <= 1'b1;
                     state  <= S_RUN;
                  end else if (bus.op == MDU_MTHI) begin
                     hi_q <= bus.rs_val;
                  end else if (bus.op == MDU_MTLO) begin
                     lo_q <= bus.rs_val;
                  end
               end
            end
            // Starts are ignored here; the result is invisible until this commit.
            S_RUN: begin
               if (cnt == CW'(1)) begin
                  {hi_q, lo_q} <= pend;
                  cnt          <= '0;
                  busy_q       <= 1'b0;
                  state        <= S_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.stall_req = busy_q | (bus.start & (is_mul_op(bus.op) | is_div_op(bus.op)));

endmodule
